// File: rtl/alu_muldiv_if.sv
// Handshake and data bundle between the execute stage and the multiply/divide unit.
// The pipeline side drives operands and takes results; the unit side does the work.
interface alu_muldiv_if #(
   parameter int DATA_WIDTH = 32,
   parameter int OP_LENGTH  = 3
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] SrcA;
   logic [DATA_WIDTH-1:0] SrcB;
   logic [OP_LENGTH-1:0]  Operation;
   logic                  flush;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] Result;

   modport master (
      output in_valid, SrcA, SrcB, Operation, flush, out_ready,
      input  in_ready, out_valid, Result
   );

   modport slave (
      input  in_valid, SrcA, SrcB, Operation, flush, out_ready,
      output in_ready, out_valid, Result
   );
endinterface

// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide unit: one bit per cycle over N cycles of shift-add
// (multiply) or restoring division, then a single sign-fix cycle. Latency never depends
// on operand values, so the pipeline sees a constant stall length.
module alu_muldiv #(
   parameter int DATA_WIDTH = 32,
   parameter int OP_LENGTH  = 3
) (
   input logic         clk,
   input logic         rst_n,
   alu_muldiv_if.slave bus
);
   localparam int N = DATA_WIDTH;

   localparam logic [OP_LENGTH-1:0] OpMul    = OP_LENGTH'(0);
   localparam logic [OP_LENGTH-1:0] OpMulh   = OP_LENGTH'(1);
   localparam logic [OP_LENGTH-1:0] OpMulhsu = OP_LENGTH'(2);
   localparam logic [OP_LENGTH-1:0] OpMulhu  = OP_LENGTH'(3);
   localparam logic [OP_LENGTH-1:0] OpDiv    = OP_LENGTH'(4);
   localparam logic [OP_LENGTH-1:0] OpDivu   = OP_LENGTH'(5);
   localparam logic [OP_LENGTH-1:0] OpRem    = OP_LENGTH'(6);
   localparam logic [OP_LENGTH-1:0] OpRemu   = OP_LENGTH'(7);

   localparam logic [N-1:0] CntLast = N'(N - 1);
   localparam logic [N-1:0] MinVal  = {1'b1, {(N-1){1'b0}}};
   localparam logic [N-1:0] OneVal  = N'(1);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t             state;
   logic [OP_LENGTH-1:0] opReg;
   logic [N-1:0]       srcAReg;
   logic [N-1:0]       divisor;
   logic [2*N-1:0]     aShift;
   logic [N-1:0]       bShift;
   logic [2*N-1:0]     acc;
   logic [N-1:0]       cnt;
   logic               signA;
   logic               signB;
   logic [N-1:0]       resultReg;
   logic               outValidReg;

   logic               isDivOp;
   logic               aSignedIn;
   logic               bSignedIn;
   logic [N-1:0]       absA;
   logic [N-1:0]       absB;
   logic [2*N-1:0]     mulAcc;
   logic [N:0]         remShift;
   logic [N:0]         remSub;
   logic               takeSub;
   logic [2*N-1:0]     prodFix;
   logic [N-1:0]       quoFix;
   logic [N-1:0]       remFix;
   logic               divZero;
   logic               overflow;
   logic [N-1:0]       fixResult;

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = outValidReg;
   assign bus.Result    = resultReg;

   assign isDivOp = opReg[2];

   // Operand sign decode and magnitude extraction for the incoming operation
   always_comb begin
      aSignedIn = (bus.Operation == OpMulh) || (bus.Operation == OpMulhsu) ||
                  (bus.Operation == OpDiv)  || (bus.Operation == OpRem);
      bSignedIn = (bus.Operation == OpMulh) || (bus.Operation == OpDiv) ||
                  (bus.Operation == OpRem);
      absA = (aSignedIn && bus.SrcA[N-1]) ? (~bus.SrcA + OneVal) : bus.SrcA;
      absB = (bSignedIn && bus.SrcB[N-1]) ? (~bus.SrcB + OneVal) : bus.SrcB;
   end

   // One iteration step: shift-add partial product and restoring-divide trial subtraction
   always_comb begin
      mulAcc   = bShift[0] ? (acc + aShift) : acc;
      remShift = {acc[N-1:0], aShift[N-1]};
      remSub   = remShift - {1'b0, divisor};
      takeSub  = (remShift >= {1'b0, divisor});
   end

   // Sign correction and divide special cases applied in the FIX cycle
   always_comb begin
      prodFix  = (signA ^ signB) ? (~acc + 1'b1) : acc;
      quoFix   = (signA ^ signB) ? (~acc[2*N-1:N] + OneVal) : acc[2*N-1:N];
      remFix   = signA ? (~acc[N-1:0] + OneVal) : acc[N-1:0];
      divZero  = (divisor == '0);
      overflow = ((opReg == OpDiv) || (opReg == OpRem)) && signB &&
                 (srcAReg == MinVal) && (divisor == OneVal);
      fixResult = '0;
      case (opReg)
         OpMul:                     fixResult = prodFix[N-1:0];
         OpMulh, OpMulhsu, OpMulhu: fixResult = prodFix[2*N-1:N];
         OpDiv, OpDivu: begin
            if (divZero)       fixResult = '1;
            else if (overflow) fixResult = srcAReg;
            else               fixResult = quoFix;
         end
         OpRem, OpRemu: begin
            if (divZero)       fixResult = srcAReg;
            else if (overflow) fixResult = '0;
            else               fixResult = remFix;
         end
         default:                   fixResult = '0;
      endcase
   end

   // Control FSM and datapath registers; flush overrides every transition
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         opReg       <= '0;
         srcAReg     <= '0;
         divisor     <= '0;
         aShift      <= '0;
         bShift      <= '0;
         acc         <= '0;
         cnt         <= '0;
         signA       <= 1'b0;
         signB       <= 1'b0;
         resultReg   <= '0;
         outValidReg <= 1'b0;
      end else if (bus.flush) begin
         state       <= IDLE;
         outValidReg <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  opReg   <= bus.Operation;
                  srcAReg <= bus.SrcA;
                  signA   <= aSignedIn && bus.SrcA[N-1];
                  signB   <= bSignedIn && bus.SrcB[N-1];
                  aShift  <= {{N{1'b0}}, absA};
                  bShift  <= absB;
                  divisor <= absB;
                  acc     <= '0;
                  cnt     <= '0;
                  state   <= CALC;
               end
            end
            CALC: begin
               aShift <= aShift << 1;
               if (isDivOp) begin
                  acc[N-1:0]   <= takeSub ? remSub[N-1:0] : remShift[N-1:0];
                  acc[2*N-1:N] <= {acc[2*N-2:N], takeSub};
               end else begin
                  acc    <= mulAcc;
                  bShift <= bShift >> 1;
               end
               if (cnt == CntLast) begin
                  cnt   <= '0;
                  state <= FIX;
               end else begin
                  cnt <= cnt + OneVal;
               end
            end
            FIX: begin
               resultReg   <= fixResult;
               outValidReg <= 1'b1;
               state       <= DONE;
            end
            DONE: begin
               if (bus.out_ready) begin
                  outValidReg <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv at N=32: a vector table for the arithmetic and special
// cases, followed by hand-written handshake, flush and reset sequences.
module tb_alu_muldiv;
   localparam int N = 32;
   localparam int LatencyExp = N + 1;

   localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
   localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   alu_muldiv_if #(.DATA_WIDTH(N), .OP_LENGTH(3)) bus ();

   alu_muldiv #(.DATA_WIDTH(N), .OP_LENGTH(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Free-running clock, 10 time-unit period
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[$];
   int compared = 0;
   int mismatched = 0;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
      end
   endtask

   // Presents one operation at a negedge and returns at the negedge after the acceptance edge.
   task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                input bit holdValid);
      int guard;
      guard = 0;
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.Operation = op;
      bus.SrcA      = a;
      bus.SrcB      = b;
      while (bus.in_ready !== 1'b1 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 100) checkOutput("accept_timeout", {31'b0, bus.in_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      if (!holdValid) bus.in_valid = 1'b0;
      bus.SrcA      = ~a;
      bus.SrcB      = b ^ 32'h5A5A_5A5A;
      bus.Operation = ~op;
   endtask

   // Counts edges from the acceptance edge (edge 0) until out_valid is seen, bounded.
   task automatic waitResult(output logic [31:0] res, output int lat);
      lat = 0;
      while (bus.out_valid !== 1'b1 && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      res = bus.Result;
   endtask

   task automatic consume();
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
   endtask

   logic [31:0] res;
   int lat;
   bit stable;
   bit sawValid;

   initial begin
      bus.in_valid  = 1'b0;
      bus.SrcA      = '0;
      bus.SrcB      = '0;
      bus.Operation = '0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b0;

      vecs.push_back('{"mul_7x6",        MUL,    32'd7,        32'd6,        32'd42});
      vecs.push_back('{"mul_neg3x5",     MUL,    32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1});
      vecs.push_back('{"mul_lo_shift",   MUL,    32'h12345678, 32'h10,       32'h23456780});
      vecs.push_back('{"mulh_min_min",   MULH,   32'h80000000, 32'h80000000, 32'h40000000});
      vecs.push_back('{"mulh_neg3x5",    MULH,   32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF});
      vecs.push_back('{"mulhu_max_max",  MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE});
      vecs.push_back('{"mulhu_shift",    MULHU,  32'h12345678, 32'h10,       32'h00000001});
      vecs.push_back('{"mulhsu_m1x2",    MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF});
      vecs.push_back('{"div_m7_2",       DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD});
      vecs.push_back('{"rem_m7_2",       REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF});
      vecs.push_back('{"div_7_m2",       DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD});
      vecs.push_back('{"rem_7_m2",       REM,    32'd7,        32'hFFFFFFFE, 32'd1});
      vecs.push_back('{"divu_big_2",     DIVU,   32'hFFFFFFFE, 32'd2,        32'h7FFFFFFF});
      vecs.push_back('{"remu_100_7",     REMU,   32'd100,      32'd7,        32'd2});
      vecs.push_back('{"div_5_0",        DIV,    32'd5,        32'd0,        32'hFFFFFFFF});
      vecs.push_back('{"divu_5_0",       DIVU,   32'd5,        32'd0,        32'hFFFFFFFF});
      vecs.push_back('{"remu_5_0",       REMU,   32'd5,        32'd0,        32'd5});
      vecs.push_back('{"rem_m7_0",       REM,    32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9});
      vecs.push_back('{"div_ovf",        DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000});
      vecs.push_back('{"rem_ovf",        REM,    32'h80000000, 32'hFFFFFFFF, 32'd0});

      #12;
      checkOutput("reset_in_ready",  {31'b0, bus.in_ready},  32'd1);
      checkOutput("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
      checkOutput("reset_result",    bus.Result,             32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
         waitResult(res, lat);
         checkOutput(vecs[i].name, res, vecs[i].exp);
         checkOutput({vecs[i].name, "_lat"}, 32'(lat), 32'(LatencyExp));
         consume();
      end

      // Back-pressure with in_valid held high and operands changed during CALC
      applyStimulus(MUL, 32'd3, 32'd4, 1'b1);
      bus.Operation = MUL;
      bus.SrcA      = 32'd5;
      bus.SrcB      = 32'd5;
      waitResult(res, lat);
      checkOutput("bp_first_result", res, 32'd12);
      checkOutput("bp_first_lat", 32'(lat), 32'(LatencyExp));
      stable = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (bus.Result !== 32'd12 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) stable = 1'b0;
      end
      checkOutput("bp_hold_stable", {31'b0, stable}, 32'd1);
      consume();
      checkOutput("bp_idle_in_ready",  {31'b0, bus.in_ready},  32'd1);
      checkOutput("bp_idle_out_valid", {31'b0, bus.out_valid}, 32'd0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      checkOutput("bp_second_accepted", {31'b0, bus.in_ready}, 32'd0);
      waitResult(res, lat);
      checkOutput("bp_second_result", res, 32'd25);
      checkOutput("bp_second_lat", 32'(lat), 32'(LatencyExp));
      consume();

      // Flush in the fifth CALC cycle
      applyStimulus(MUL, 32'd9, 32'd9, 1'b0);
      repeat (4) @(negedge clk);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      checkOutput("flush_calc_in_ready", {31'b0, bus.in_ready}, 32'd1);
      sawValid = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (bus.out_valid === 1'b1) sawValid = 1'b1;
      end
      checkOutput("flush_calc_no_valid", {31'b0, sawValid}, 32'd0);
      checkOutput("flush_calc_result_kept", bus.Result, 32'd25);

      // Flush in DONE drops the result without a handshake
      applyStimulus(MUL, 32'd2, 32'd3, 1'b0);
      waitResult(res, lat);
      checkOutput("flush_done_result", res, 32'd6);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      checkOutput("flush_done_out_valid", {31'b0, bus.out_valid}, 32'd0);
      checkOutput("flush_done_in_ready",  {31'b0, bus.in_ready},  32'd1);
      checkOutput("flush_done_result_kept", bus.Result, 32'd6);

      // Flush together with in_valid in IDLE must not accept
      bus.in_valid  = 1'b1;
      bus.flush     = 1'b1;
      bus.Operation = MUL;
      bus.SrcA      = 32'd11;
      bus.SrcB      = 32'd11;
      @(negedge clk);
      checkOutput("flush_idle_not_accepted", {31'b0, bus.in_ready}, 32'd1);
      bus.in_valid = 1'b0;
      bus.flush    = 1'b0;
      sawValid = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (bus.out_valid === 1'b1) sawValid = 1'b1;
      end
      checkOutput("flush_idle_no_valid", {31'b0, sawValid}, 32'd0);

      // Asynchronous reset in the middle of CALC, then a clean operation
      applyStimulus(MUL, 32'd7, 32'd6, 1'b0);
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("midreset_out_valid", {31'b0, bus.out_valid}, 32'd0);
      checkOutput("midreset_in_ready",  {31'b0, bus.in_ready},  32'd1);
      checkOutput("midreset_result",    bus.Result,             32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(MUL, 32'd7, 32'd6, 1'b0);
      waitResult(res, lat);
      checkOutput("post_reset_mul", res, 32'd42);
      checkOutput("post_reset_lat", 32'(lat), 32'(LatencyExp));
      consume();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
